// File: rtl/sat_vec_alu_pkg.sv
// Shared types and helpers for the saturating vector ALU.
// Opcode encoding is fixed by the instruction decoder that drives this unit.
package sat_vec_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    // Helpers return 64-bit patterns; callers keep only their low w bits.
    localparam int MAX_W = 64;

    // Largest positive two's-complement value of a w-bit lane: 0111...1
    function automatic logic [MAX_W-1:0] sat_max(input int unsigned w);
        sat_max = (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    endfunction

    // Most negative two's-complement value of a w-bit lane: 1000...0
    function automatic logic [MAX_W-1:0] sat_min(input int unsigned w);
        sat_min = MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/sat_lane.sv
// One lane of the saturating ALU: purely combinational.
// The sum is formed in W+1 bits from sign-extended operands, so the two top
// bits disagreeing means the W-bit result overflowed; bit W gives the
// direction of the overflow.
module sat_lane
    import sat_vec_alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_acc,
    input  op_e          i_op,
    output logic [W-1:0] o_s,
    output logic         o_ovf
);

    localparam logic [W-1:0] MAXV = W'(sat_max(W));
    localparam logic [W-1:0] MINV = W'(sat_min(W));

    logic [W-1:0] w_x;
    logic [W-1:0] w_y;
    logic         w_cin;
    logic [W:0]   w_r;
    logic         w_pos_ovf;
    logic         w_neg_ovf;

    // Select the effective operands and carry-in for the opcode
    always_comb begin
        w_x   = i_a;
        w_y   = i_b;
        w_cin = 1'b0;
        case (i_op)
            OP_SUB: begin
                w_y   = ~i_b;
                w_cin = 1'b1;
            end
            OP_ACC: begin
                w_x = i_acc;
                w_y = i_a;
            end
            default: begin
                w_x   = i_a;
                w_y   = i_b;
                w_cin = 1'b0;
            end
        endcase
    end

    assign w_r = {w_x[W-1], w_x} + {w_y[W-1], w_y} + {{W{1'b0}}, w_cin};

    assign w_pos_ovf = ~w_r[W] &  w_r[W-1];
    assign w_neg_ovf =  w_r[W] & ~w_r[W-1];

    // Clamp on overflow; CLR forces a clean zero regardless of operands
    always_comb begin
        o_s   = w_r[W-1:0];
        o_ovf = w_pos_ovf | w_neg_ovf;
        if (i_op == OP_CLR) begin
            o_s   = '0;
            o_ovf = 1'b0;
        end else if (w_pos_ovf) begin
            o_s = MAXV;
        end else if (w_neg_ovf) begin
            o_s = MINV;
        end
    end

endmodule

// File: rtl/sat_vec_alu.sv
// LANES-wide saturating add/sub/accumulate unit with a 2-stage pipeline.
// Optional feature: define SATALU_OVF_COUNT_EN to add the ovf_count output
// (overflow-beat counter, saturating, cleared with clr_sticky).
//
// Handshake: a beat moves on a port when valid & ready are both high at the
// rising edge; valid never depends on ready; data is held while valid & ~ready.
// Stage 1 only registers operands. Stage 2 does the arithmetic and owns the
// accumulators, so back-to-back ACC beats chain without a bubble.
module sat_vec_alu
    import sat_vec_alu_pkg::*;
#(
    parameter int W     = 8,
    parameter int LANES = 4
`ifdef SATALU_OVF_COUNT_EN
    , parameter int CW  = 16
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic [LANES*W-1:0] in_a,
    input  logic [LANES*W-1:0] in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] out_s,
    output logic [LANES-1:0]   out_ovf,
    output logic               sticky_ovf,
    input  logic               clr_sticky
`ifdef SATALU_OVF_COUNT_EN
    , output logic [CW-1:0]    ovf_count
`endif
);

    localparam int N = LANES * W;

    logic         r_s1_valid;
    op_e          r_s1_op;
    logic [N-1:0] r_s1_a;
    logic [N-1:0] r_s1_b;

    logic             r_s2_valid;
    logic [N-1:0]     r_out_s;
    logic [LANES-1:0] r_out_ovf;
    logic [N-1:0]     r_acc;
    logic             r_sticky;

    logic             w_s2_adv;
    logic             w_in_fire;
    logic [N-1:0]     w_s;
    logic [LANES-1:0] w_ovf;
    logic             w_ovf_evt;

    assign w_s2_adv  = r_s1_valid & (~r_s2_valid | out_ready);
    assign in_ready  = ~r_s1_valid | w_s2_adv;
    assign w_in_fire = in_valid & in_ready;
    assign w_ovf_evt = w_s2_adv & (|w_ovf);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sat_lane #(.W(W)) u_lane (
            .i_a   (r_s1_a[g*W +: W]),
            .i_b   (r_s1_b[g*W +: W]),
            .i_acc (r_acc[g*W +: W]),
            .i_op  (r_s1_op),
            .o_s   (w_s[g*W +: W]),
            .o_ovf (w_ovf[g])
        );
    end

    // Stage 1: capture a beat on input transfer, empty when stage 2 takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= OP_ADD;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_op    <= op_e'(op);
            r_s1_a     <= in_a;
            r_s1_b     <= in_b;
        end else if (w_s2_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: register lane results and update accumulators for ACC/CLR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_out_s    <= '0;
            r_out_ovf  <= '0;
            r_acc      <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= 1'b1;
            r_out_s    <= w_s;
            r_out_ovf  <= w_ovf;
            if (r_s1_op == OP_ACC || r_s1_op == OP_CLR) begin
                r_acc <= w_s;
            end
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    // Sticky overflow flag; a new overflow beat wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
        end else if (w_ovf_evt) begin
            r_sticky <= 1'b1;
        end else if (clr_sticky) begin
            r_sticky <= 1'b0;
        end
    end

`ifdef SATALU_OVF_COUNT_EN
    logic [CW-1:0] r_ovf_count;

    // Saturating overflow-beat counter; clear with a same-cycle event leaves 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_count <= '0;
        end else if (clr_sticky) begin
            r_ovf_count <= {{(CW-1){1'b0}}, w_ovf_evt};
        end else if (w_ovf_evt && (r_ovf_count != {CW{1'b1}})) begin
            r_ovf_count <= r_ovf_count + CW'(1);
        end
    end

    assign ovf_count = r_ovf_count;
`endif

    assign out_valid  = r_s2_valid;
    assign out_s      = r_out_s;
    assign out_ovf    = r_out_ovf;
    assign sticky_ovf = r_sticky;

endmodule
